// File: rtl/tff_counter_pkg.sv
// rtl/tff_counter_pkg.sv - shared constants and helpers for the T flip-flop up/down counter
package tff_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Largest count value for a given modulus, as a 16-bit constant
  function automatic logic [15:0] max_val(input int unsigned modulus);
    return 16'(modulus - 1);
  endfunction

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop bit with async reset and parallel load
module tff_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic ld_val,
  output logic q,
  output logic qb
);

  // Bit state: reset to RST_BIT, load overrides toggle, t=1 toggles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_BIT;
    end else if (ld) begin
      q <= ld_val;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/tff_updown_counter.sv
// rtl/tff_updown_counter.sv - modulo-N up/down counter built from a row of T flip-flop cells
module tff_updown_counter
  import tff_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX     = WIDTH'(max_val(MODULUS));
  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] ld_val;
  logic             at_max;
  logic             at_zero;
  logic             wrap_evt;

  assign at_max  = (q == MAX);
  assign at_zero = (q == '0);

  // Count-path next value; the T inputs are the bits that must flip to reach it
  always_comb begin
    cnt_next = q;
    if (en) begin
      if (up == DIR_UP) begin
        cnt_next = at_max ? '0 : q + WIDTH'(1);
      end else begin
        cnt_next = at_zero ? MAX : q - WIDTH'(1);
      end
    end
    t = load ? '0 : (q ^ cnt_next);
  end

  // Out-of-range load values saturate to the top of the count range
  assign ld_val = (d > MAX) ? MAX : d;

  // A wrap happens exactly when an enabled, non-load edge leaves the terminal value
  assign wrap_evt = en & ~load & ((up == DIR_UP) ? at_max : at_zero);
  assign tc       = wrap_evt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(
      .RST_BIT (RST_VEC[i])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .t      (t[i]),
      .ld     (load),
      .ld_val (ld_val[i]),
      .q      (q[i]),
      .qb     (qb[i])
    );
  end

  // Sticky wrap flag; a wrap on the same edge as clr_wrap keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else if (wrap_evt) begin
      wrap <= 1'b1;
    end else if (clr_wrap) begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tff_updown_counter.sv
// tb/tb_tff_updown_counter.sv - scoreboard bench for tff_updown_counter with a modulo-arithmetic model
module tb_tff_updown_counter;

  typedef struct packed {
    logic [11:0] q;
    logic [2:0]  tc;
    logic [2:0]  wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d = 4'd0;
  logic       clr_wrap = 1'b0;

  logic [3:0] q_a [3];
  logic [3:0] qb_a [3];
  logic       tc_a [3];
  logic       wrap_a [3];

  int mods [3] = '{10, 10, 16};
  int rvs  [3] = '{0, 3, 0};
  int m_cnt [3];
  bit m_wrp [3];

  exp_t sb [$];
  int   vectors = 0;
  int   errors  = 0;

  tff_updown_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d), .clr_wrap(clr_wrap),
    .q(q_a[0]), .qb(qb_a[0]), .tc(tc_a[0]), .wrap(wrap_a[0]));

  tff_updown_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(3)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d), .clr_wrap(clr_wrap),
    .q(q_a[1]), .qb(qb_a[1]), .tc(tc_a[1]), .wrap(wrap_a[1]));

  tff_updown_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d), .clr_wrap(clr_wrap),
    .q(q_a[2]), .qb(qb_a[2]), .tc(tc_a[2]), .wrap(wrap_a[2]));

  always #5 clk = ~clk;

  // Expected outputs from the model state and the inputs currently applied
  function automatic exp_t snap();
    exp_t x;
    x = '0;
    for (int i = 0; i < 3; i++) begin
      x.q[i*4 +: 4] = 4'(m_cnt[i]);
      x.tc[i]       = en & ~load & (up ? (m_cnt[i] == mods[i] - 1) : (m_cnt[i] == 0));
      x.wrap[i]     = m_wrp[i];
    end
    return x;
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, got, exp);
    end
  endtask

  // One clock of stimulus; expectations are queued for the rst rise (if any) and the coming edge
  task automatic step(input logic r, input logic ld, input logic [3:0] dv,
                      input logic e, input logic u, input logic c);
    bit boundary;
    @(negedge clk);
    load = ld; d = dv; en = e; up = u; clr_wrap = c;
    if (r && !rst) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = rvs[i];
        m_wrp[i] = 1'b0;
      end
      sb.push_back(snap());
    end
    rst = r;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_cnt[i] = rvs[i];
        m_wrp[i] = 1'b0;
      end else if (ld) begin
        m_cnt[i] = (int'(dv) < mods[i]) ? int'(dv) : mods[i] - 1;
        if (c) m_wrp[i] = 1'b0;
      end else if (e) begin
        boundary = u ? (m_cnt[i] == mods[i] - 1) : (m_cnt[i] == 0);
        m_cnt[i] = u ? (m_cnt[i] + 1) % mods[i] : (m_cnt[i] + mods[i] - 1) % mods[i];
        if (boundary) m_wrp[i] = 1'b1;
        else if (c)   m_wrp[i] = 1'b0;
      end else if (c) begin
        m_wrp[i] = 1'b0;
      end
    end
    sb.push_back(snap());
  endtask

  // Monitor: compare every presented output state against the oldest queued expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
          check("q",    i, q_a[i],           x.q[i*4 +: 4]);
          check("qb",   i, qb_a[i],          ~x.q[i*4 +: 4]);
          check("tc",   i, {3'b0, tc_a[i]},  {3'b0, x.tc[i]});
          check("wrap", i, {3'b0, wrap_a[i]}, {3'b0, x.wrap[i]});
        end
      end
    end
  end

  initial begin
    int waited;
    // reset
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    // count up across the 9 -> 0 wrap
    repeat (12) step(0, 0, 0, 1, 1, 0);
    // down from 0 after a fresh reset
    step(1, 0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    // saturating load with en high, then an in-range load
    step(0, 1, 4'd13, 1, 1, 0);
    step(0, 1, 4'd5, 1, 1, 0);
    // hold, then direction changes
    repeat (3) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    // wrap set beats clr_wrap on the same edge, then clear alone
    step(0, 1, 4'd9, 0, 1, 0);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    // async reset mid-count, hold in reset, release and count
    step(0, 1, 4'd7, 0, 1, 0);
    step(1, 1, 4'd2, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    // natural rollover on the full-range instance
    step(0, 1, 4'd15, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 10), 4'($urandom),
           ($urandom_range(99) < 70), 1'($urandom), ($urandom_range(99) < 15));
    end
    step(0, 0, 0, 0, 1, 0);
    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
